// File: rtl/fibo_pkg.sv
// Shared types and constants for the Fibonacci term-stream checker.
package fibo_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    GOT0     = 2'd1,
    LOCKED   = 2'd2,
    RESEED   = 2'd3
  } state_e;

  localparam int WIDTH_DEF = 4;
  localparam int SEED0     = 0;
  localparam int SEED1     = 1;

endpackage

// File: rtl/fibo_expect_unit.sv
// Combinational next-term prediction (prev + cur mod 2^WIDTH) and compare.
module fibo_expect_unit #(
  parameter int WIDTH = fibo_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] exp_o,
  output logic             carry_o,
  output logic             match_o
);

  if (WIDTH == 4) begin : g_rca
    rcadder_4b u_add (
      .a    (prev_i),
      .b    (cur_i),
      .cin  (1'b0),
      .sum  (exp_o),
      .cout (carry_o)
    );
  end else begin : g_generic
    assign {carry_o, exp_o} = {1'b0, prev_i} + {1'b0, cur_i};
  end

  assign match_o = (sample_i == exp_o);

endmodule

// File: rtl/rcadder_4b.sv
// Four-bit ripple-carry adder built from a chain of full adders.
module rcadder_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/fibo_seq_checker.sv
// Locks onto a 0,1-seeded Fibonacci stream, re-predicts each term and
// reports matches, arithmetic wraps and mismatches with saturating counters.
module fibo_seq_checker
  import fibo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] fibo_in,
  input  logic             clear_err,
  output logic             locked,
  output logic [CNT_W-1:0] term_cnt,
  output logic             wrap_pulse,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d, cur_q, cur_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             wrap_q, wrap_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;

  logic [WIDTH-1:0] exp_term;
  logic             carry;
  logic             match;

  fibo_expect_unit #(.WIDTH(WIDTH)) u_expect (
    .prev_i   (prev_q),
    .cur_i    (cur_q),
    .sample_i (fibo_in),
    .exp_o    (exp_term),
    .carry_o  (carry),
    .match_o  (match)
  );

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    cur_d        = cur_q;
    locked_d     = locked_q;
    term_cnt_d   = term_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    wrap_d       = 1'b0;
    err_pulse_d  = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        UNLOCKED: begin
          if (fibo_in == WIDTH'(SEED0)) begin
            cur_d   = WIDTH'(SEED0);
            state_d = GOT0;
          end
        end
        GOT0: begin
          if (fibo_in == WIDTH'(SEED1)) begin
            prev_d     = WIDTH'(SEED0);
            cur_d      = WIDTH'(SEED1);
            locked_d   = 1'b1;
            term_cnt_d = CNT_W'(2);
            state_d    = LOCKED;
          end else if (fibo_in != WIDTH'(SEED0)) begin
            state_d = UNLOCKED;
          end
        end
        LOCKED: begin
          if (match) begin
            prev_d     = cur_q;
            cur_d      = fibo_in;
            wrap_d     = carry;
            term_cnt_d = (term_cnt_q == '1) ? term_cnt_q : term_cnt_q + CNT_W'(1);
          end else begin
            err_pulse_d  = 1'b1;
            err_sticky_d = 1'b1;
            err_cnt_d    = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);
            cur_d        = fibo_in;
            state_d      = RESEED;
          end
        end
        RESEED: begin
          // Accept one term blind so the checker can follow a running stream.
          prev_d     = cur_q;
          cur_d      = fibo_in;
          term_cnt_d = (term_cnt_q == '1) ? term_cnt_q : term_cnt_q + CNT_W'(1);
          state_d    = LOCKED;
        end
        default: state_d = UNLOCKED;
      endcase
    end

    // Clear wins over a same-cycle mismatch for counters, not for the pulse.
    if (clear_err) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= UNLOCKED;
      prev_q       <= '0;
      cur_q        <= '0;
      locked_q     <= 1'b0;
      term_cnt_q   <= '0;
      err_cnt_q    <= '0;
      wrap_q       <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      cur_q        <= cur_d;
      locked_q     <= locked_d;
      term_cnt_q   <= term_cnt_d;
      err_cnt_q    <= err_cnt_d;
      wrap_q       <= wrap_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign locked     = locked_q;
  assign term_cnt   = term_cnt_q;
  assign wrap_pulse = wrap_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

endmodule
